// File: rtl/sram_access_ctrl_pkg.sv
// Shared types and constants for the SRAM access controller.
package sram_access_ctrl_pkg;

  // Access sequencer states: idle, low half-word, high half-word, completion
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int unsigned ADDR_BASE_DEFAULT = 1024;
  localparam int unsigned SRAM_AW           = 18;
  localparam int unsigned SRAM_DW           = 16;
  localparam int unsigned WAIT_CW           = 3;

  // Half-word SRAM address for a byte address: word index relative to the
  // base (unsigned wrap below the base), low 17 bits, then the phase bit.
  function automatic logic [SRAM_AW-1:0] sram_half_addr(
    input logic [31:0] byte_addr,
    input logic [31:0] base,
    input logic        half
  );
    return SRAM_AW'({(byte_addr - base) >> 2, half});
  endfunction

endpackage

// File: rtl/sram_access_ctrl_wait_counter.sv
// Loadable 3-bit wait-state down-counter shared by the LO and HI phases.
// Exposes the zero flag of the current count and the count that will be
// present next cycle, so the sequencer can register its strobes ahead.
module sram_wait_counter
  import sram_access_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rest,
  input  logic               load_i,
  input  logic [WAIT_CW-1:0] load_val_i,
  input  logic               dec_i,
  output logic               zero_o,
  output logic [WAIT_CW-1:0] count_next_o
);

  localparam logic [WAIT_CW-1:0] ONE = WAIT_CW'(1);

  logic [WAIT_CW-1:0] count_q;
  logic [WAIT_CW-1:0] count_d;

  // Next count: a load wins over a decrement; decrement stops at zero
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - ONE;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o       = (count_q == '0);
  assign count_next_o = count_d;

endmodule

// File: rtl/sram_access_ctrl.sv
// Sequences one 32-bit load/store from the execute stage onto a 16-bit
// asynchronous SRAM as a low half-word access followed by a high half-word
// access, each WAIT_STATES+1 cycles long, and holds the pipeline meanwhile.
//
// Handshake: the request (rd_en | wr_en) together with address and
// write_data is held stable by the pipeline while freeze is high; ready is a
// single-cycle pulse in the completion cycle, during which freeze drops so
// the pipeline advances; the next request is taken in the following cycle.
module sram_access_ctrl
  import sram_access_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned ADDR_BASE   = ADDR_BASE_DEFAULT
) (
  input  logic               clk,
  input  logic               rest,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic               freeze,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_we_n,
  output state_e             dbg_state
);

  localparam logic [WAIT_CW-1:0] WS          = WAIT_CW'(WAIT_STATES);
  localparam logic [31:0]        BASE        = 32'(ADDR_BASE);
  // With no wait states there is no separate hold cycle, so the strobe
  // covers the whole single-cycle phase.
  localparam bit                 STROBE_FULL = (WAIT_STATES == 0);

  state_e             state_q;
  logic               wr_q;
  logic [31:0]        read_data_q;
  logic               ready_q;
  logic [SRAM_AW-1:0] addr_q;
  logic [SRAM_DW-1:0] dq_out_q;
  logic               dq_oe_q;
  logic               we_n_q;

  logic               req;
  logic               cnt_load;
  logic               cnt_dec;
  logic               cnt_zero;
  logic [WAIT_CW-1:0] cnt_next;
  logic               strobe_next;

  assign req = rd_en | wr_en;

  // Counter is loaded on entry to each phase and counts down inside it
  assign cnt_load = ((state_q == ST_IDLE) && req) ||
                    ((state_q == ST_LO) && cnt_zero);
  assign cnt_dec  = ((state_q == ST_LO) || (state_q == ST_HI)) && !cnt_zero;

  sram_wait_counter u_wait_counter (
    .clk          (clk),
    .rest         (rest),
    .load_i       (cnt_load),
    .load_val_i   (WS),
    .dec_i        (cnt_dec),
    .zero_o       (cnt_zero),
    .count_next_o (cnt_next)
  );

  // Write strobe for a phase cycle: low while wait states remain, released
  // in the last cycle of the phase so address and data are held past it
  assign strobe_next = (cnt_next != '0) || STROBE_FULL;

  // Sequencer with registered SRAM-side outputs computed for the next cycle
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_q     <= ST_IDLE;
      wr_q        <= 1'b0;
      read_data_q <= '0;
      ready_q     <= 1'b0;
      addr_q      <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      we_n_q      <= 1'b1;
    end else begin
      ready_q <= 1'b0;
      dq_oe_q <= 1'b0;
      we_n_q  <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            state_q <= ST_LO;
            wr_q    <= wr_en;
            addr_q  <= sram_half_addr(address, BASE, 1'b0);
            if (wr_en) begin
              dq_out_q <= write_data[15:0];
              dq_oe_q  <= 1'b1;
              we_n_q   <= !strobe_next;
            end
          end
        end
        ST_LO: begin
          if (wr_q) begin
            dq_oe_q <= 1'b1;
            we_n_q  <= !strobe_next;
          end
          if (cnt_zero) begin
            state_q <= ST_HI;
            addr_q  <= sram_half_addr(address, BASE, 1'b1);
            if (wr_q) begin
              dq_out_q <= write_data[31:16];
            end else begin
              read_data_q[15:0] <= sram_dq_in;
            end
          end
        end
        ST_HI: begin
          if (cnt_zero) begin
            state_q <= ST_DONE;
            ready_q <= 1'b1;
            if (!wr_q) begin
              read_data_q[31:16] <= sram_dq_in;
            end
          end else if (wr_q) begin
            dq_oe_q <= 1'b1;
            we_n_q  <= !strobe_next;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Hold the pipeline while a request is outstanding; released in DONE and
  // while reset is asserted
  assign freeze = req && (state_q != ST_DONE) && rest;

  assign read_data   = read_data_q;
  assign ready       = ready_q;
  assign sram_addr   = addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_we_n   = we_n_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: one instance with one wait state (index 0)
// and one with none (index 1), each attached to a half-word SRAM model.
module tb_sram_access_ctrl;

  localparam int HW = 1 << 18;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rest_s = 2'b00;
  logic [1:0]       rd_en_s = 2'b00;
  logic [1:0]       wr_en_s = 2'b00;
  logic [1:0][31:0] address_s = '0;
  logic [1:0][31:0] write_data_s = '0;
  logic [1:0][31:0] read_data_s;
  logic [1:0]       ready_s;
  logic [1:0]       freeze_s;
  logic [1:0][17:0] sram_addr_s;
  logic [1:0][15:0] sram_dq_out_s;
  logic [1:0][15:0] sram_dq_in_s;
  logic [1:0]       sram_dq_oe_s;
  logic [1:0]       sram_we_n_s;
  logic [1:0][1:0]  dbg_s;

  sram_access_ctrl #(.WAIT_STATES(1), .ADDR_BASE(1024)) u_dut_w1 (
    .clk(clk), .rest(rest_s[0]), .rd_en(rd_en_s[0]), .wr_en(wr_en_s[0]),
    .address(address_s[0]), .write_data(write_data_s[0]),
    .read_data(read_data_s[0]), .ready(ready_s[0]), .freeze(freeze_s[0]),
    .sram_addr(sram_addr_s[0]), .sram_dq_out(sram_dq_out_s[0]),
    .sram_dq_oe(sram_dq_oe_s[0]), .sram_dq_in(sram_dq_in_s[0]),
    .sram_we_n(sram_we_n_s[0]), .dbg_state(dbg_s[0])
  );

  sram_access_ctrl #(.WAIT_STATES(0), .ADDR_BASE(1024)) u_dut_w0 (
    .clk(clk), .rest(rest_s[1]), .rd_en(rd_en_s[1]), .wr_en(wr_en_s[1]),
    .address(address_s[1]), .write_data(write_data_s[1]),
    .read_data(read_data_s[1]), .ready(ready_s[1]), .freeze(freeze_s[1]),
    .sram_addr(sram_addr_s[1]), .sram_dq_out(sram_dq_out_s[1]),
    .sram_dq_oe(sram_dq_oe_s[1]), .sram_dq_in(sram_dq_in_s[1]),
    .sram_we_n(sram_we_n_s[1]), .dbg_state(dbg_s[1])
  );

  // ---------------- SRAM models ----------------
  logic [15:0] mem0 [HW];
  logic [15:0] mem1 [HW];

  assign sram_dq_in_s[0] = mem0[sram_addr_s[0]];
  assign sram_dq_in_s[1] = mem1[sram_addr_s[1]];

  always @(negedge clk) begin
    if (!sram_we_n_s[0]) mem0[sram_addr_s[0]] = sram_dq_out_s[0];
    if (!sram_we_n_s[1]) mem1[sram_addr_s[1]] = sram_dq_out_s[1];
  end

  // ---------------- reference model / scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [31:0] ref_mem [int];
  logic [31:0] last_rd_a = '0;
  logic [31:0] exp_q [$];
  logic [17:0] we_addr_q [$];

  function automatic int ref_word(input logic [31:0] a);
    logic [31:0] d;
    d = (a - 32'd1024) >> 2;
    return int'(d & 32'h0001_FFFF);
  endfunction

  function automatic logic [31:0] ref_read(input int w);
    if (ref_mem.exists(w)) return ref_mem[w];
    return 32'h0;
  endfunction

  function automatic int lat_exp(input int ws);
    return 2 * (ws + 1) + 1;
  endfunction

  // ---------------- driver ----------------
  // Presents one request at a negedge (cycle 0 = IDLE decision cycle), then
  // observes #1 after each negedge until a few cycles past the ready pulse.
  task automatic run_op(input int u, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] data,
                        output int lat, output int frz, output int rdy,
                        output int we_lo, output int oe_hi,
                        output logic [31:0] rdata);
    bit seen;
    int tail;
    seen = 0; tail = 0; lat = -1; frz = 0; rdy = 0; we_lo = 0; oe_hi = 0;
    rdata = '0;
    we_addr_q.delete();
    @(negedge clk);
    rd_en_s[u] = rd; wr_en_s[u] = wr;
    address_s[u] = addr; write_data_s[u] = data;
    for (int c = 0; c < 64; c++) begin
      #1;
      if (freeze_s[u]) frz++;
      if (!sram_we_n_s[u]) begin
        we_lo++;
        we_addr_q.push_back(sram_addr_s[u]);
      end
      if (sram_dq_oe_s[u]) oe_hi++;
      if (ready_s[u]) begin
        rdy++;
        if (!seen) begin
          seen = 1; lat = c; rdata = read_data_s[u];
          rd_en_s[u] = 1'b0; wr_en_s[u] = 1'b0; tail = c + 3;
        end
      end
      if (seen && c >= tail) break;
      @(negedge clk);
    end
    rd_en_s[u] = 1'b0; wr_en_s[u] = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    rd_en_s = 2'b11;
    #1;
    for (int u = 0; u < 2; u++) begin
      total++; if (read_data_s[u] !== 32'h0) begin bad++; $display("FAIL rst_read_data[%0d] got=%h exp=0", u, read_data_s[u]); end
      total++; if (ready_s[u] !== 1'b0) begin bad++; $display("FAIL rst_ready[%0d] got=%b exp=0", u, ready_s[u]); end
      total++; if (freeze_s[u] !== 1'b0) begin bad++; $display("FAIL rst_freeze[%0d] got=%b exp=0", u, freeze_s[u]); end
      total++; if (sram_addr_s[u] !== 18'h0) begin bad++; $display("FAIL rst_sram_addr[%0d] got=%h exp=0", u, sram_addr_s[u]); end
      total++; if (sram_dq_out_s[u] !== 16'h0) begin bad++; $display("FAIL rst_dq_out[%0d] got=%h exp=0", u, sram_dq_out_s[u]); end
      total++; if (sram_dq_oe_s[u] !== 1'b0) begin bad++; $display("FAIL rst_dq_oe[%0d] got=%b exp=0", u, sram_dq_oe_s[u]); end
      total++; if (sram_we_n_s[u] !== 1'b1) begin bad++; $display("FAIL rst_we_n[%0d] got=%b exp=1", u, sram_we_n_s[u]); end
    end
    rd_en_s = 2'b00;
    @(negedge clk);
    rest_s = 2'b11;
    last_rd_a = '0;
  endtask

  task automatic test_write();
    int lat, frz, rdy, we_lo, oe_hi;
    logic [31:0] rdata;
    ref_mem[ref_word(32'd1024)] = 32'hDEAD_BEEF;
    run_op(0, 1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF, lat, frz, rdy, we_lo, oe_hi, rdata);
    total++; if (lat !== lat_exp(1)) begin bad++; $display("FAIL wr_latency got=%0d exp=%0d", lat, lat_exp(1)); end
    total++; if (frz !== lat_exp(1)) begin bad++; $display("FAIL wr_freeze_cycles got=%0d exp=%0d", frz, lat_exp(1)); end
    total++; if (rdy !== 1) begin bad++; $display("FAIL wr_ready_count got=%0d exp=1", rdy); end
    total++; if (we_lo !== 2) begin bad++; $display("FAIL wr_we_low_cycles got=%0d exp=2", we_lo); end
    total++; if (oe_hi !== 4) begin bad++; $display("FAIL wr_oe_cycles got=%0d exp=4", oe_hi); end
    total++; if (mem0[0] !== 16'hBEEF) begin bad++; $display("FAIL wr_mem_lo got=%h exp=beef", mem0[0]); end
    total++; if (mem0[1] !== 16'hDEAD) begin bad++; $display("FAIL wr_mem_hi got=%h exp=dead", mem0[1]); end
    total++; if (rdata !== last_rd_a) begin bad++; $display("FAIL wr_read_data_kept got=%h exp=%h", rdata, last_rd_a); end
  endtask

  task automatic test_read();
    int lat, frz, rdy, we_lo, oe_hi;
    logic [31:0] rdata;
    mem0[2] = 16'h5678; mem0[3] = 16'h1234;
    ref_mem[ref_word(32'd1028)] = 32'h1234_5678;
    last_rd_a = ref_read(ref_word(32'd1028));
    run_op(0, 1'b1, 1'b0, 32'd1028, 32'h0, lat, frz, rdy, we_lo, oe_hi, rdata);
    total++; if (rdata !== 32'h1234_5678) begin bad++; $display("FAIL rd_data got=%h exp=12345678", rdata); end
    total++; if (lat !== lat_exp(1)) begin bad++; $display("FAIL rd_latency got=%0d exp=%0d", lat, lat_exp(1)); end
    total++; if (oe_hi !== 0) begin bad++; $display("FAIL rd_oe_cycles got=%0d exp=0", oe_hi); end
    total++; if (we_lo !== 0) begin bad++; $display("FAIL rd_we_low_cycles got=%0d exp=0", we_lo); end
  endtask

  task automatic test_back_to_back();
    int first, second;
    logic [31:0] rdata;
    first = -1; second = -1; rdata = '0;
    ref_mem[ref_word(32'd1032)] = 32'hA5A5_0F0F;
    @(negedge clk);
    rd_en_s[0] = 1'b0; wr_en_s[0] = 1'b1;
    address_s[0] = 32'd1032; write_data_s[0] = 32'hA5A5_0F0F;
    for (int c = 0; c < 64; c++) begin
      #1;
      if (ready_s[0]) begin
        if (first < 0) begin
          first = c;
          rd_en_s[0] = 1'b1; wr_en_s[0] = 1'b0;
        end else begin
          second = c; rdata = read_data_s[0];
          rd_en_s[0] = 1'b0;
          break;
        end
      end
      @(negedge clk);
    end
    rd_en_s[0] = 1'b0; wr_en_s[0] = 1'b0;
    last_rd_a = ref_read(ref_word(32'd1032));
    total++; if (first !== lat_exp(1)) begin bad++; $display("FAIL b2b_first_ready got=%0d exp=%0d", first, lat_exp(1)); end
    total++; if (second - first !== lat_exp(1) + 1) begin bad++; $display("FAIL b2b_ready_gap got=%0d exp=%0d", second - first, lat_exp(1) + 1); end
    total++; if (rdata !== last_rd_a) begin bad++; $display("FAIL b2b_read_data got=%h exp=%h", rdata, last_rd_a); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    int lat, frz, rdy, we_lo, oe_hi;
    logic [31:0] rdata;
    ref_mem[ref_word(32'd1036)] = 32'h1111_2222;
    run_op(0, 1'b1, 1'b1, 32'd1036, 32'h1111_2222, lat, frz, rdy, we_lo, oe_hi, rdata);
    total++; if (mem0[6] !== 16'h2222) begin bad++; $display("FAIL both_mem_lo got=%h exp=2222", mem0[6]); end
    total++; if (mem0[7] !== 16'h1111) begin bad++; $display("FAIL both_mem_hi got=%h exp=1111", mem0[7]); end
    total++; if (rdata !== last_rd_a) begin bad++; $display("FAIL both_read_data_kept got=%h exp=%h", rdata, last_rd_a); end
    total++; if (we_lo !== 2) begin bad++; $display("FAIL both_we_low_cycles got=%0d exp=2", we_lo); end
  endtask

  task automatic test_idle();
    int busy;
    busy = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (freeze_s[0] || ready_s[0] || sram_dq_oe_s[0] || !sram_we_n_s[0]) busy++;
    end
    total++; if (busy !== 0) begin bad++; $display("FAIL idle_pins_active got=%0d cycles exp=0", busy); end
  endtask

  task automatic test_reset_mid_hi();
    int lat, frz, rdy, we_lo, oe_hi, stray;
    logic [31:0] rdata;
    logic [31:0] d;
    d = $urandom;
    @(negedge clk);
    rd_en_s[0] = 1'b0; wr_en_s[0] = 1'b1;
    address_s[0] = 32'd1040; write_data_s[0] = d;
    repeat (3) @(negedge clk);
    #1;
    total++; if (sram_addr_s[0] !== 18'd9) begin bad++; $display("FAIL midhi_addr got=%h exp=9", sram_addr_s[0]); end
    rest_s[0] = 1'b0;
    #1;
    total++; if (ready_s[0] !== 1'b0) begin bad++; $display("FAIL midhi_ready got=%b exp=0", ready_s[0]); end
    total++; if (freeze_s[0] !== 1'b0) begin bad++; $display("FAIL midhi_freeze got=%b exp=0", freeze_s[0]); end
    total++; if (sram_addr_s[0] !== 18'h0) begin bad++; $display("FAIL midhi_sram_addr got=%h exp=0", sram_addr_s[0]); end
    total++; if (sram_we_n_s[0] !== 1'b1) begin bad++; $display("FAIL midhi_we_n got=%b exp=1", sram_we_n_s[0]); end
    total++; if (sram_dq_oe_s[0] !== 1'b0) begin bad++; $display("FAIL midhi_dq_oe got=%b exp=0", sram_dq_oe_s[0]); end
    total++; if (read_data_s[0] !== 32'h0) begin bad++; $display("FAIL midhi_read_data got=%h exp=0", read_data_s[0]); end
    wr_en_s[0] = 1'b0;
    @(negedge clk);
    rest_s[0] = 1'b1;
    last_rd_a = '0;
    stray = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      if (ready_s[0]) stray++;
    end
    total++; if (stray !== 0) begin bad++; $display("FAIL midhi_stray_ready got=%0d exp=0", stray); end
    d = $urandom;
    ref_mem[ref_word(32'd1040)] = d;
    run_op(0, 1'b0, 1'b1, 32'd1040, d, lat, frz, rdy, we_lo, oe_hi, rdata);
    total++; if (lat !== lat_exp(1)) begin bad++; $display("FAIL after_rst_latency got=%0d exp=%0d", lat, lat_exp(1)); end
    total++; if ({mem0[9], mem0[8]} !== d) begin bad++; $display("FAIL after_rst_mem got=%h exp=%h", {mem0[9], mem0[8]}, d); end
  endtask

  task automatic test_random();
    int lat, frz, rdy, we_lo, oe_hi, w;
    logic [31:0] rdata, addr, data, exp;
    logic rd, wr;
    for (int i = 0; i < 24; i++) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if (!rd && !wr) rd = 1'b1;
      addr = 32'd1024 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      data = $urandom;
      w = ref_word(addr);
      if (wr) ref_mem[w] = data;
      else last_rd_a = ref_read(w);
      exp_q.push_back(last_rd_a);
      run_op(0, rd, wr, addr, data, lat, frz, rdy, we_lo, oe_hi, rdata);
      exp = exp_q.pop_front();
      total++; if (rdata !== exp) begin bad++; $display("FAIL rnd%0d_read_data got=%h exp=%h", i, rdata, exp); end
      total++; if (lat !== lat_exp(1) || frz !== lat_exp(1) || rdy !== 1) begin bad++; $display("FAIL rnd%0d_timing lat=%0d frz=%0d rdy=%0d exp=%0d/%0d/1", i, lat, frz, rdy, lat_exp(1), lat_exp(1)); end
      if (wr) begin
        total++; if ({mem0[2*w+1], mem0[2*w]} !== data) begin bad++; $display("FAIL rnd%0d_mem got=%h exp=%h", i, {mem0[2*w+1], mem0[2*w]}, data); end
        total++; if (we_lo !== 2 || oe_hi !== 4) begin bad++; $display("FAIL rnd%0d_wr_pins we_lo=%0d oe=%0d exp=2/4", i, we_lo, oe_hi); end
      end else begin
        total++; if (we_lo !== 0 || oe_hi !== 0) begin bad++; $display("FAIL rnd%0d_rd_pins we_lo=%0d oe=%0d exp=0/0", i, we_lo, oe_hi); end
      end
    end
  endtask

  task automatic test_wait0();
    int lat, frz, rdy, we_lo, oe_hi;
    logic [31:0] rdata, d;
    mem1[0] = 16'hCAFE; mem1[1] = 16'hBABE;
    run_op(1, 1'b1, 1'b0, 32'd1024, 32'h0, lat, frz, rdy, we_lo, oe_hi, rdata);
    total++; if (lat !== lat_exp(0)) begin bad++; $display("FAIL w0_latency got=%0d exp=%0d", lat, lat_exp(0)); end
    total++; if (frz !== lat_exp(0)) begin bad++; $display("FAIL w0_freeze_cycles got=%0d exp=%0d", frz, lat_exp(0)); end
    total++; if (rdata !== 32'hBABE_CAFE) begin bad++; $display("FAIL w0_read_data got=%h exp=babecafe", rdata); end
    d = $urandom;
    run_op(1, 1'b0, 1'b1, 32'd0, d, lat, frz, rdy, we_lo, oe_hi, rdata);
    total++; if (we_lo !== 2) begin bad++; $display("FAIL w0_we_low_cycles got=%0d exp=2", we_lo); end
    if (we_addr_q.size() == 2) begin
      total++; if (we_addr_q[0] !== 18'h3FE00) begin bad++; $display("FAIL w0_wrap_addr_lo got=%h exp=3fe00", we_addr_q[0]); end
      total++; if (we_addr_q[1] !== 18'h3FE01) begin bad++; $display("FAIL w0_wrap_addr_hi got=%h exp=3fe01", we_addr_q[1]); end
    end
    total++; if ({mem1[18'h3FE01], mem1[18'h3FE00]} !== d) begin bad++; $display("FAIL w0_wrap_mem got=%h exp=%h", {mem1[18'h3FE01], mem1[18'h3FE00]}, d); end
    run_op(1, 1'b1, 1'b0, 32'd0, 32'h0, lat, frz, rdy, we_lo, oe_hi, rdata);
    total++; if (rdata !== d) begin bad++; $display("FAIL w0_wrap_readback got=%h exp=%h", rdata, d); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    for (int i = 0; i < HW; i++) begin
      mem0[i] = 16'h0;
      mem1[i] = 16'h0;
    end
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_simultaneous();
    test_idle();
    test_reset_mid_hi();
    test_random();
    test_wait0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
